// File: rtl/bcd_1000_countdown_sar_if.sv
// bcd_1000_countdown_sar_if
// Groups the control inputs and status outputs of the BCD countdown timer.
// The clock and reset are not part of this bundle; they stay plain ports on the
// timer module.
//   en        count tick, one decrement per clk edge while running
//   load      synchronous load strobe for load_val
//   load_val  BCD preset: [3:0] units, [7:4] tens, [11:8] hundreds
//   start     request to move from IDLE to RUN
//   stop      request to move from RUN to IDLE (count is held)
//   cnt       registered BCD count
//   busy      high while the timer is running
//   done      one-cycle terminal-count pulse
//   load_err  sticky flag: the last load contained a nibble above 9
// modport master : the side that drives the controls (for example a CPU or a testbench)
// modport slave  : the timer itself
interface bcd_1000_countdown_sar_if;
  logic        en;
  logic        load;
  logic [11:0] load_val;
  logic        start;
  logic        stop;
  logic [11:0] cnt;
  logic        busy;
  logic        done;
  logic        load_err;

  modport master (
    output en, load, load_val, start, stop,
    input  cnt, busy, done, load_err
  );

  modport slave (
    input  en, load, load_val, start, stop,
    output cnt, busy, done, load_err
  );
endinterface

// File: rtl/bcd_1000_countdown_sar.sv
// bcd_1000_countdown_sar
// Three-digit 8421 BCD down-counter, 999..000. It is used as a loadable
// countdown timer. A small IDLE/RUN/DONE control FSM handles load, start and
// stop, and it produces a one-cycle done pulse on the terminal tick. When
// AUTO_RELOAD is set, the preset is reloaded on the tick after 000, which turns
// the block into a periodic timer.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    bcd_1000_countdown_sar_if.slave
//          inputs : en, load, load_val, start, stop
//          outputs: cnt, busy, done, load_err
// Parameters:
//   AUTO_RELOAD  0: stop at 000 and park in DONE
//                1: reload the preset and keep running
//   RESET_VAL    BCD value that cnt and the reload register take on reset
module bcd_1000_countdown_sar #(
  parameter bit          AUTO_RELOAD = 1'b0,
  parameter logic [11:0] RESET_VAL   = 12'h000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  bcd_1000_countdown_sar_if.slave       bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [11:0] reload_q, reload_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic [11:0] load_fixed;
  logic        load_bad;

  // A nibble above 9 is not a BCD digit. It is forced to 9 so that cnt never
  // shows an illegal digit.
  function automatic logic [3:0] clamp_nibble(input logic [3:0] n);
    return (n > 4'd9) ? 4'd9 : n;
  endfunction

  // Borrow-rippling BCD decrement. Units always step. Tens step only when the
  // units wrap. Hundreds step only when both lower digits wrap.
  function automatic logic [11:0] bcd_dec(input logic [11:0] v);
    logic [3:0] u, t, h;
    u = v[3:0];
    t = v[7:4];
    h = v[11:8];
    if (u == 4'd0) begin
      u = 4'd9;
      if (t == 4'd0) begin
        t = 4'd9;
        h = (h == 4'd0) ? 4'd9 : h - 4'd1;
      end else begin
        t = t - 4'd1;
      end
    end else begin
      u = u - 4'd1;
    end
    return {h, t, u};
  endfunction

  assign load_fixed = {clamp_nibble(bus.load_val[11:8]),
                       clamp_nibble(bus.load_val[7:4]),
                       clamp_nibble(bus.load_val[3:0])};
  assign load_bad   = (bus.load_val[11:8] > 4'd9) ||
                      (bus.load_val[7:4]  > 4'd9) ||
                      (bus.load_val[3:0]  > 4'd9);

  // Next-state logic. The priority is load > stop > start > en.
  // done is a pulse, so it defaults to 0 on every edge and is raised only on
  // the terminal tick. That tick needs cnt == 001, so done can never be high
  // two cycles in a row.
  // In RUN, cnt reads 000 only after a terminal tick with auto-reload enabled.
  // The next en tick then brings back the preset instead of decrementing.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    err_d    = err_q;

    if (bus.load) begin
      cnt_d    = load_fixed;
      reload_d = load_fixed;
      err_d    = load_bad;
      state_d  = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (!bus.stop && bus.start && (cnt_q != 12'h000)) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (bus.stop) begin
            state_d = IDLE;
          end else if (bus.en) begin
            if (cnt_q == 12'h001) begin
              cnt_d  = 12'h000;
              done_d = 1'b1;
              if (!AUTO_RELOAD || (reload_q == 12'h000)) begin
                state_d = DONE;
              end
            end else if (cnt_q == 12'h000) begin
              if (AUTO_RELOAD) begin
                cnt_d = reload_q;
              end else begin
                state_d = DONE;
              end
            end else begin
              cnt_d = bcd_dec(cnt_q);
            end
          end
        end
        DONE: begin
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State register. Reset aborts any count in progress at once and does not
  // issue a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= RESET_VAL;
      reload_q <= RESET_VAL;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // busy decodes the state register only, so there is no path from the inputs.
  assign bus.cnt      = cnt_q;
  assign bus.busy     = (state_q == RUN);
  assign bus.done     = done_q;
  assign bus.load_err = err_q;

endmodule

// File: tb/tb_bcd_1000_countdown_sar.sv
// tb_bcd_1000_countdown_sar
// Directed bench for bcd_1000_countdown_sar. It runs two instances:
//   dut0  AUTO_RELOAD = 0, the single-shot timer
//   dut1  AUTO_RELOAD = 1, the periodic timer
// Both instances share clk and rst_n. Inputs change 1 ns after a rising edge,
// and outputs are sampled at the same point.
module tb_bcd_1000_countdown_sar;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   done_pulses;

  bcd_1000_countdown_sar_if bus0 ();
  bcd_1000_countdown_sar_if bus1 ();

  bcd_1000_countdown_sar #(.AUTO_RELOAD(1'b0), .RESET_VAL(12'h000)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.slave)
  );

  bcd_1000_countdown_sar #(.AUTO_RELOAD(1'b1), .RESET_VAL(12'h000)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of controls on the selected instance, hold the other one
  // quiet, then move to 1 ns past the next rising edge.
  task automatic applyStimulus(input bit sel, input logic ld, input logic [11:0] lv,
                               input logic st, input logic sp, input logic e);
    if (sel == 1'b0) begin
      bus0.load = ld; bus0.load_val = lv; bus0.start = st; bus0.stop = sp; bus0.en = e;
      bus1.load = 1'b0; bus1.start = 1'b0; bus1.stop = 1'b0; bus1.en = 1'b0;
    end else begin
      bus1.load = ld; bus1.load_val = lv; bus1.start = st; bus1.stop = sp; bus1.en = e;
      bus0.load = 1'b0; bus0.start = 1'b0; bus0.stop = 1'b0; bus0.en = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [11:0] observed,
                             input logic [11:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    done_pulses = 0;
    rst_n = 1'b0;
    bus0.en = 0; bus0.load = 0; bus0.load_val = 0; bus0.start = 0; bus0.stop = 0;
    bus1.en = 0; bus1.load = 0; bus1.load_val = 0; bus1.start = 0; bus1.stop = 0;
    #3;
    checkOutput("reset_cnt",  bus0.cnt, 12'h000);
    checkOutput("reset_busy", {11'd0, bus0.busy}, 12'h000);
    checkOutput("reset_done", {11'd0, bus0.done}, 12'h000);
    checkOutput("reset_err",  {11'd0, bus0.load_err}, 12'h000);
    #9 rst_n = 1'b1;
    $display("[TB] reset released");

    // 1: countdown from 005 to terminal
    applyStimulus(0, 1, 12'h005, 0, 0, 0);
    checkOutput("t1_load_cnt", bus0.cnt, 12'h005);
    applyStimulus(0, 0, 12'h000, 1, 0, 0);
    checkOutput("t1_busy_run", {11'd0, bus0.busy}, 12'h001);
    applyStimulus(0, 0, 12'h000, 0, 0, 1);
    checkOutput("t1_cnt004", bus0.cnt, 12'h004);
    applyStimulus(0, 0, 12'h000, 0, 0, 1);
    checkOutput("t1_cnt003", bus0.cnt, 12'h003);
    applyStimulus(0, 0, 12'h000, 0, 0, 1);
    checkOutput("t1_cnt002", bus0.cnt, 12'h002);
    applyStimulus(0, 0, 12'h000, 0, 0, 1);
    checkOutput("t1_cnt001", bus0.cnt, 12'h001);
    checkOutput("t1_done_early", {11'd0, bus0.done}, 12'h000);
    applyStimulus(0, 0, 12'h000, 0, 0, 1);
    checkOutput("t1_cnt000", bus0.cnt, 12'h000);
    checkOutput("t1_done_pulse", {11'd0, bus0.done}, 12'h001);
    checkOutput("t1_busy_fall", {11'd0, bus0.busy}, 12'h000);
    applyStimulus(0, 0, 12'h000, 1, 0, 1);
    checkOutput("t1_done_single", {11'd0, bus0.done}, 12'h000);
    checkOutput("t1_done_state_hold", bus0.cnt, 12'h000);
    checkOutput("t1_start_ignored", {11'd0, bus0.busy}, 12'h000);

    // 2: borrow across digits, then a full 999-tick run
    applyStimulus(0, 1, 12'h100, 0, 0, 0);
    applyStimulus(0, 0, 12'h000, 1, 0, 0);
    applyStimulus(0, 0, 12'h000, 0, 0, 1);
    checkOutput("t2_cnt099", bus0.cnt, 12'h099);
    applyStimulus(0, 0, 12'h000, 0, 0, 1);
    checkOutput("t2_cnt098", bus0.cnt, 12'h098);
    applyStimulus(0, 1, 12'h999, 0, 0, 0);
    applyStimulus(0, 0, 12'h000, 1, 0, 0);
    applyStimulus(0, 0, 12'h000, 0, 0, 1);
    checkOutput("t2_cnt998", bus0.cnt, 12'h998);
    if (bus0.done) done_pulses++;
    for (int i = 2; i <= 999; i++) begin
      applyStimulus(0, 0, 12'h000, 0, 0, 1);
      if (bus0.done) done_pulses++;
      if (i == 900) checkOutput("t2_cnt099_mid", bus0.cnt, 12'h099);
    end
    checkOutput("t2_final_cnt", bus0.cnt, 12'h000);
    checkOutput("t2_final_done", {11'd0, bus0.done}, 12'h001);
    checkOutput("t2_pulse_count", done_pulses[11:0], 12'd1);

    // 4: en gating, stop beats start, resume from the held count
    applyStimulus(0, 1, 12'h050, 0, 0, 0);
    applyStimulus(0, 0, 12'h000, 1, 0, 0);
    applyStimulus(0, 0, 12'h000, 0, 0, 1);
    checkOutput("t4_cnt049", bus0.cnt, 12'h049);
    applyStimulus(0, 0, 12'h000, 0, 0, 0);
    checkOutput("t4_hold049", bus0.cnt, 12'h049);
    applyStimulus(0, 0, 12'h000, 0, 0, 1);
    checkOutput("t4_cnt048", bus0.cnt, 12'h048);
    applyStimulus(0, 0, 12'h000, 0, 0, 0);
    checkOutput("t4_hold048", bus0.cnt, 12'h048);
    applyStimulus(0, 0, 12'h000, 1, 1, 1);
    checkOutput("t4_stop_busy", {11'd0, bus0.busy}, 12'h000);
    checkOutput("t4_stop_cnt", bus0.cnt, 12'h048);
    applyStimulus(0, 0, 12'h000, 0, 0, 1);
    checkOutput("t4_idle_no_count", bus0.cnt, 12'h048);
    applyStimulus(0, 0, 12'h000, 1, 0, 0);
    checkOutput("t4_resume_busy", {11'd0, bus0.busy}, 12'h001);
    applyStimulus(0, 0, 12'h000, 0, 0, 1);
    checkOutput("t4_resume_cnt", bus0.cnt, 12'h047);

    // 5: clamping and load_err, load beats start
    applyStimulus(0, 1, 12'h3A7, 0, 0, 0);
    checkOutput("t5_clamp_cnt", bus0.cnt, 12'h397);
    checkOutput("t5_err_set", {11'd0, bus0.load_err}, 12'h001);
    checkOutput("t5_load_stops", {11'd0, bus0.busy}, 12'h000);
    applyStimulus(0, 1, 12'hFBC, 0, 0, 0);
    checkOutput("t5_clamp_all", bus0.cnt, 12'h999);
    applyStimulus(0, 1, 12'h123, 0, 0, 0);
    checkOutput("t5_err_clear", {11'd0, bus0.load_err}, 12'h000);
    checkOutput("t5_cnt123", bus0.cnt, 12'h123);
    applyStimulus(0, 1, 12'h200, 1, 0, 0);
    checkOutput("t5_load_start_busy", {11'd0, bus0.busy}, 12'h000);
    checkOutput("t5_load_start_cnt", bus0.cnt, 12'h200);

    // 6: asynchronous reset mid-run, then start at 000 is ignored
    applyStimulus(0, 1, 12'h045, 0, 0, 0);
    applyStimulus(0, 0, 12'h000, 1, 0, 0);
    applyStimulus(0, 0, 12'h000, 0, 0, 1);
    applyStimulus(0, 0, 12'h000, 0, 0, 1);
    applyStimulus(0, 0, 12'h000, 0, 0, 1);
    checkOutput("t6_cnt042", bus0.cnt, 12'h042);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_cnt", bus0.cnt, 12'h000);
    checkOutput("t6_rst_busy", {11'd0, bus0.busy}, 12'h000);
    checkOutput("t6_rst_done", {11'd0, bus0.done}, 12'h000);
    #2 rst_n = 1'b1;
    applyStimulus(0, 0, 12'h000, 1, 0, 1);
    checkOutput("t6_start_zero_busy", {11'd0, bus0.busy}, 12'h000);
    checkOutput("t6_start_zero_done", {11'd0, bus0.done}, 12'h000);
    checkOutput("t6_start_zero_cnt", bus0.cnt, 12'h000);

    // 3: auto-reload on dut1, with a period of 3 en ticks
    applyStimulus(1, 1, 12'h002, 0, 0, 0);
    applyStimulus(1, 0, 12'h000, 1, 0, 0);
    checkOutput("t3_cnt002", bus1.cnt, 12'h002);
    applyStimulus(1, 0, 12'h000, 0, 0, 1);
    checkOutput("t3_cnt001", bus1.cnt, 12'h001);
    applyStimulus(1, 0, 12'h000, 0, 0, 1);
    checkOutput("t3_cnt000", bus1.cnt, 12'h000);
    checkOutput("t3_done1", {11'd0, bus1.done}, 12'h001);
    checkOutput("t3_busy_stays", {11'd0, bus1.busy}, 12'h001);
    applyStimulus(1, 0, 12'h000, 0, 0, 1);
    checkOutput("t3_reload", bus1.cnt, 12'h002);
    checkOutput("t3_done_low", {11'd0, bus1.done}, 12'h000);
    applyStimulus(1, 0, 12'h000, 0, 0, 1);
    checkOutput("t3_cnt001b", bus1.cnt, 12'h001);
    applyStimulus(1, 0, 12'h000, 0, 0, 1);
    checkOutput("t3_cnt000b", bus1.cnt, 12'h000);
    checkOutput("t3_done2", {11'd0, bus1.done}, 12'h001);
    applyStimulus(1, 0, 12'h000, 0, 0, 1);
    checkOutput("t3_reload2", bus1.cnt, 12'h002);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
